// File: rtl/muldiv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : muldiv_pkg
// Description : Shared definitions for the HI/LO multiply/divide unit:
//               ALU control codes, sequencer state encoding, default width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    // ALU control codes handled by the HI/LO unit (shared with the ALU decoder)
    localparam logic [3:0] CTL_MULTU = 4'b1100;
    localparam logic [3:0] CTL_DIVU  = 4'b1101;
    localparam logic [3:0] CTL_MULT  = 4'b1110;
    localparam logic [3:0] CTL_DIV   = 4'b1111;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // True for any code owned by this unit (bit0 = divide, bit1 = signed)
    function automatic logic is_muldiv(input logic [3:0] ctl);
        return (ctl[3:2] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : muldiv_step
// Description : One combinational iteration of the sequencer. Multiply does a
//               shift-add step on {upper, multiplier}; divide does a restoring
//               step on {remainder, quotient}.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Single iteration; the shifted remainder keeps its carry-out bit so the
    // trial compare is exact for divisors with the MSB set.
    always_comb begin
        w_mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        w_rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        w_ge      = (w_rem_sh >= {1'b0, operand});
        w_diff    = w_rem_sh[WIDTH-1:0] - operand;
        acc_next  = {w_mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (w_ge) begin
                acc_next = {w_diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {w_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : muldiv_sequencer
// Description : Multi-cycle HI/LO unit (MULTU/DIVU/MULT/DIV). One iteration per
//               clock, results committed to HI/LO in a final fix-up cycle.
//               Stalls the pipeline while an operation is in flight.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Request decode and operand magnitude / final sign correction
    always_comb begin
        w_accept = start & is_muldiv(control) & (r_state == IDLE);
        w_a_neg  = control[1] & in1[WIDTH-1];
        w_b_neg  = control[1] & in2[WIDTH-1];
        w_abs_a  = w_a_neg ? (~in1 + 1'b1) : in1;
        w_abs_b  = w_b_neg ? (~in2 + 1'b1) : in2;
        w_prod   = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quot   = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem    = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (r_acc),
        .operand  (r_op),
        .is_div   (r_is_div),
        .acc_next (w_acc_next)
    );

    // Sequencer FSM with architectural HI/LO and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // mthi/mtlo only land while idle; an accepted op overwrites at FIX
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (w_accept) begin
                        r_busy   <= 1'b1;
                        r_dz     <= 1'b0;
                        r_cnt    <= '0;
                        r_is_div <= control[0];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        if (control[0] && (in2 == '0)) begin
                            // Divide by zero: park the final HI/LO values and skip CALC
                            r_zero  <= 1'b1;
                            r_op    <= '0;
                            r_acc   <= {in1, {WIDTH{1'b1}}};
                            r_state <= FIX;
                        end else begin
                            // Multiply: operand = multiplicand, low half = multiplier.
                            // Divide:   operand = divisor,      low half = dividend.
                            r_zero  <= 1'b0;
                            r_op    <= control[0] ? w_abs_b : w_abs_a;
                            r_acc   <= {{WIDTH{1'b0}}, (control[0] ? w_abs_a : w_abs_b)};
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (r_zero) begin
                        r_hi <= r_acc[2*WIDTH-1:WIDTH];
                        r_lo <= r_acc[WIDTH-1:0];
                        r_dz <= 1'b1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign stall = r_busy | w_accept;
    assign done  = r_done;
    assign dz    = r_dz;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_muldiv_sequencer;

    localparam logic [3:0] MULTU = 4'b1100;
    localparam logic [3:0] DIVU  = 4'b1101;
    localparam logic [3:0] MULT  = 4'b1110;
    localparam logic [3:0] DIV   = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  control;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        stall;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int n;

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .control (control),
        .in1     (in1),
        .in2     (in2),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .wdata   (wdata),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .dz      (dz),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request on a negedge, let it be sampled at T0
    task automatic start_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; control = ctl; in1 = a; in2 = b;
        #1 chk("stall_on_request", stall, 1);
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_T0", busy, 1);
        chk("dz_cleared_at_T0", dz, 0);
    endtask

    // Count edges after T0 until done is seen (bounded)
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            cnt++;
            #1;
            if (done) break;
            chk("busy_while_running", busy, 1);
        end
        chk("busy_low_with_done", busy, 0);
    endtask

    task automatic check_done_drops();
        @(posedge clk);
        #1 chk("done_one_cycle", done, 0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz, input int elat);
        int c;
        start_op(ctl, a, b);
        wait_done(c);
        chk({tag, "_latency"}, c, elat);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
        chk({tag, "_dz"}, dz, edz);
        check_done_drops();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; control = 4'b0000; in1 = '0; in2 = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dz", dz, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal control code: start must be ignored
        @(negedge clk);
        start = 1'b1; control = 4'b0110; in1 = 32'd3; in2 = 32'd4;
        #1 chk("illegal_stall", stall, 0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("illegal_busy", busy, 0);

        // 1: MULTU max*max
        run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
        // 2: signed multiplies
        run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
        run_op("mult_min", MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33);
        // 3: divides
        run_op("divu", DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 33);
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
        run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33);
        run_op("divu_bigdiv", DIVU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 32'h00000001, 1'b0, 33);
        // 4: divide by zero, then dz cleared by next op
        run_op("div_zero", DIV, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 1);
        run_op("multu_small", MULTU, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0, 33);

        // 5: start and mthi while busy are ignored; HI/LO hold during CALC
        start_op(MULTU, 32'h00000010, 32'h00000020);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start = 1'b1; control = DIVU; in1 = 32'd9; in2 = 32'd3;
        hi_we = 1'b1; wdata = 32'hAAAAAAAA;
        #1 chk("busy_stall", stall, 1);
        chk("hold_hi_mid", hi, 32'h00000000);
        chk("hold_lo_mid", lo, 32'h00000006);
        @(posedge clk);
        #1 start = 1'b0; hi_we = 1'b0;
        chk("mthi_ignored_busy", hi, 32'h00000000);
        wait_done(n);
        chk("busy_case_latency", n + 10, 33);
        chk("busy_case_hi", hi, 32'h00000000);
        chk("busy_case_lo", lo, 32'h00000200);
        check_done_drops();
        chk("no_queued_op", busy, 0);
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h55555555;
        @(posedge clk);
        #1 lo_we = 1'b0;
        chk("mtlo_idle_lo", lo, 32'h55555555);
        chk("mtlo_idle_hi", hi, 32'h00000000);

        // 6: reset mid-operation aborts and clears HI/LO
        start_op(DIV, 32'h00000064, 32'h00000007);
        repeat (14) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_after_rst", MULTU, 32'd7, 32'd6, 32'h00000000, 32'h0000002A, 1'b0, 33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle HI/LO unit that executes the ALU control codes 1100–1111: unsigned multiply, unsigned divide, signed multiply and signed divide.
- One iteration per clock: shift-add for multiply, restoring algorithm for divide.
- Results are held in architectural HI/LO registers, read by mfhi/mflo and written directly by mthi/mtlo.
- Sits beside the single-cycle ALU in the EX stage. It raises a stall to the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- control  in  4  ALU control code: 1100 MULTU, 1101 DIVU, 1110 MULT, 1111 DIV; other codes make start ignored.
- in1  in  WIDTH  rs operand (multiplicand / dividend).
- in2  in  WIDTH  rt operand (multiplier / divisor).
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  operation in flight.
- stall  out  1  = busy | (start & legal control & IDLE).
- done  out  1  one-cycle completion pulse.
- dz  out  1  divide-by-zero flag; valid with done.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
Reset (async, rst_n=0):
- state=IDLE; busy, done, dz = 0; hi = lo = 0; counter = 0.
- Reset mid-operation aborts the operation; HI/LO are cleared.

States: IDLE, CALC, FIX.

IDLE:
- start with a legal code at edge T0:
  - latch operands (absolute values if signed);
  - record result signs: product/quotient negative = sign(in1) xor sign(in2); remainder sign = sign(in1);
  - clear the 2*WIDTH accumulator and counter;
  - go to CALC.
- Divide with in2 == 0: go straight to FIX and flag dz.

CALC:
- One iteration per edge, T1..T32; counter increments.
- Multiply: if multiplier LSB is set, add the multiplicand to the upper half; then shift right 1, with the adder carry going into the MSB.
- Divide: shift {rem,quot} left 1; trial-subtract the divisor from rem; if no borrow, keep the difference and set quot LSB.
- Leave CALC when counter == WIDTH-1 has been processed; go to FIX.

FIX (edge T33):
- Apply two's-complement negation per the recorded signs.
- Write HI/LO:
  - multiply: HI = upper half, LO = lower half;
  - divide: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = in1 unmodified, dz=1.
- Signed -2^WIDTH-1 / -1: LO = 0x80000000, HI = 0, no flag.
- Return to IDLE; done=1 for exactly the following cycle.

Timing:
- Normal latency: done is high in the cycle after edge T33 (33 edges after start is sampled).
- Divide by zero: done is high after edge T1.
- busy is high from after T0 until done rises. busy and done are never high together.

Boundary and priority rules:
- start while busy: ignored, not queued.
- hi_we/lo_we while IDLE: write on the next edge; HI/LO update in the same edge.
- hi_we/lo_we while busy: ignored; the FIX write wins.
- hi_we/lo_we in the same cycle as an accepted start: the write lands, then is overwritten at FIX.
- hi/lo hold their previous values throughout CALC; no partial results are visible.
- dz clears on the next accepted start or on reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - localparams for the control codes (CTL_MULTU=4'b1100, CTL_DIVU=4'b1101, CTL_MULT=4'b1110, CTL_DIV=4'b1111), reused by the ALU decoder;
  - state encodings (IDLE=2'd0, CALC=2'd1, FIX=2'd2);
  - WIDTH default.
- One natural sub-module: muldiv_step, a combinational single iteration. Inputs: accumulator, operand, mode. Outputs: next accumulator. The sequencer owns all registers.

Test Plan:
1. MULTU in1=FFFFFFFF, in2=FFFFFFFF → after 33 edges: done=1, hi=FFFFFFFE, lo=00000001, dz=0; busy high for the preceding 33 cycles.
2. MULT in1=FFFFFFFD (-3), in2=00000005 → hi=FFFFFFFF, lo=FFFFFFF1. Repeat with in1=80000000, in2=80000000 → hi=40000000, lo=00000000.
3. DIVU 00000064 / 00000007 → lo=0000000E, hi=00000002. DIV FFFFFFF9 (-7) / 00000002 → lo=FFFFFFFD, hi=FFFFFFFF. DIV 80000000 / FFFFFFFF → lo=80000000, hi=00000000.
4. DIV in1=12345678, in2=0 → done after 1 edge, dz=1, lo=FFFFFFFF, hi=12345678. Next MULTU 2*3 clears dz → lo=00000006.
5. Start MULTU, then at cycle 10 pulse start (DIVU) and hi_we with wdata=AAAAAAAA → both ignored; final hi/lo equal the MULTU result. In IDLE, lo_we with 55555555 → lo=55555555 next cycle.
6. Start DIV, drop rst_n at cycle 15 → busy=done=0, hi=lo=0 immediately. After release, a new MULTU 7*6 yields lo=0000002A.
